// File: rtl/id_char_gen_if.sv
// Character-stream bus for id_char_gen.
// The request side (start, counts, first letter, hold) comes from the master.
// The per-cycle character stream and status flags come back from the slave.
interface id_char_gen_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] let_num;
  logic [CNT_W-1:0] dig_num;
  logic [4:0]       first_char;
  logic             hold;
  logic [7:0]       char_out;
  logic             char_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, let_num, dig_num, first_char, hold,
    input  char_out, char_valid, busy, done
  );

  modport slave (
    input  start, let_num, dig_num, first_char, hold,
    output char_out, char_valid, busy, done
  );
endinterface

// File: rtl/id_char_gen.sv
// Identifier stream generator.
// On a start request it emits N letters, then M digits, then a '/'
// separator, one registered ASCII character per clock.
module id_char_gen #(
  parameter int CNT_W = 4
) (
  input logic         clk,
  input logic         reset,
  id_char_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LETTER, DIGIT, SEP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] let_num_q, let_num_d;
  logic [CNT_W-1:0] dig_num_q, dig_num_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [4:0]       letter_q, letter_d;
  logic [3:0]       digit_q, digit_d;
  logic [7:0]       char_q, char_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             go_letter, go_digit, go_sep;
  logic [4:0]       cur_letter;
  logic [3:0]       cur_digit;
  logic [CNT_W-1:0] cur_idx;

  // Next-state logic: pick which character to show next, then build the
  // registered outputs and the wrapped letter/digit indices for it.
  always_comb begin
    state_d    = state_q;
    let_num_d  = let_num_q;
    dig_num_d  = dig_num_q;
    idx_d      = idx_q;
    letter_d   = letter_q;
    digit_d    = digit_q;
    char_d     = char_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = done_q;
    go_letter  = 1'b0;
    go_digit   = 1'b0;
    go_sep     = 1'b0;
    cur_letter = 5'd0;
    cur_digit  = 4'd0;
    cur_idx    = '0;

    if (!(bus.hold && state_q != IDLE)) begin
      case (state_q)
        IDLE: begin
          char_d  = 8'h00;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          idx_d   = '0;
          if (bus.start) begin
            let_num_d  = bus.let_num;
            dig_num_d  = bus.dig_num;
            cur_letter = (bus.first_char > 5'd25) ? 5'd0 : bus.first_char;
            if (bus.let_num != '0)      go_letter = 1'b1;
            else if (bus.dig_num != '0) go_digit  = 1'b1;
            else                        go_sep    = 1'b1;
          end
        end
        LETTER: begin
          if (idx_q != let_num_q) begin
            cur_letter = letter_q;
            cur_idx    = idx_q;
            go_letter  = 1'b1;
          end else if (dig_num_q != '0) begin
            go_digit = 1'b1;
          end else begin
            go_sep = 1'b1;
          end
        end
        DIGIT: begin
          if (idx_q != dig_num_q) begin
            cur_digit = digit_q;
            cur_idx   = idx_q;
            go_digit  = 1'b1;
          end else begin
            go_sep = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          char_d  = 8'h00;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          idx_d   = '0;
        end
      endcase

      if (go_letter) begin
        state_d  = LETTER;
        char_d   = 8'h61 + {3'b000, cur_letter};
        letter_d = (cur_letter == 5'd25) ? 5'd0 : cur_letter + 5'd1;
        idx_d    = cur_idx + CNT_W'(1);
        valid_d  = 1'b1;
        busy_d   = 1'b1;
        done_d   = 1'b0;
      end else if (go_digit) begin
        state_d = DIGIT;
        char_d  = 8'h30 + {4'b0000, cur_digit};
        digit_d = (cur_digit == 4'd9) ? 4'd0 : cur_digit + 4'd1;
        idx_d   = cur_idx + CNT_W'(1);
        valid_d = 1'b1;
        busy_d  = 1'b1;
        done_d  = 1'b0;
      end else if (go_sep) begin
        state_d = SEP;
        char_d  = 8'h2F;
        idx_d   = '0;
        valid_d = 1'b1;
        busy_d  = 1'b1;
        done_d  = 1'b1;
      end
    end
  end

  // State and output registers; reset forces an idle, empty generator.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      let_num_q <= '0;
      dig_num_q <= '0;
      idx_q     <= '0;
      letter_q  <= 5'd0;
      digit_q   <= 4'd0;
      char_q    <= 8'h00;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      let_num_q <= let_num_d;
      dig_num_q <= dig_num_d;
      idx_q     <= idx_d;
      letter_q  <= letter_d;
      digit_q   <= digit_d;
      char_q    <= char_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.char_out   = char_q;
  assign bus.char_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_id_char_gen.sv
// Testbench for id_char_gen: table of known streams, hand-written hold /
// reset / back-to-back sequences, and randomized streams with random hold
// checked against a simple string-building reference model.
module tb_id_char_gen;

  logic clk;
  logic reset;
  int   tests;
  int   failures;

  logic [7:0] expq[$];

  typedef struct {
    int         let_n;
    int         dig_n;
    int         first;
    int         len;
    logic [255:0] exp_str;
  } vec_t;

  vec_t vecs[7];

  id_char_gen_if #(.CNT_W(4)) bus();

  id_char_gen #(.CNT_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pack a string into a table record, first character in the top used byte.
  function automatic vec_t mkVec(input int l, input int d, input int f, input string s);
    vec_t v;
    v.let_n   = l;
    v.dig_n   = d;
    v.first   = f;
    v.len     = s.len();
    v.exp_str = '0;
    for (int i = 0; i < s.len(); i++)
      v.exp_str[8*(s.len()-1-i) +: 8] = s[i];
    return v;
  endfunction

  // Reference model: the whole expected stream from the rules, using plain mod arithmetic.
  task automatic buildExpected(input int l, input int d, input int f);
    int fo;
    expq.delete();
    fo = (f > 25) ? 0 : f;
    for (int i = 0; i < l; i++) expq.push_back(8'(8'h61 + (fo + i) % 26));
    for (int j = 0; j < d; j++) expq.push_back(8'(8'h30 + j % 10));
    expq.push_back(8'h2F);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] expChar,
                             input logic expValid, input logic expBusy, input logic expDone);
    tests++;
    if (bus.char_out !== expChar || bus.char_valid !== expValid ||
        bus.busy !== expBusy || bus.done !== expDone) begin
      failures++;
      $display("[TB] FAIL %s: got char=%h valid=%b busy=%b done=%b, expected char=%h valid=%b busy=%b done=%b",
               name, bus.char_out, bus.char_valid, bus.busy, bus.done,
               expChar, expValid, expBusy, expDone);
    end
  endtask

  task automatic doStart(input int l, input int d, input int f);
    bus.let_num    = l[3:0];
    bus.dig_num    = d[3:0];
    bus.first_char = f[4:0];
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
  endtask

  // Start a stream, then walk expq one character per unheld cycle; optional random hold.
  task automatic applyStimulus(input int l, input int d, input int f,
                               input bit useHold, input string tag);
    int c;
    int holds;
    doStart(l, d, f);
    c     = 0;
    holds = 0;
    while (c < expq.size()) begin
      checkOutput($sformatf("%s[%0d]", tag, c), expq[c], 1'b1, 1'b1, c == expq.size() - 1);
      if (useHold && holds < 3 && $urandom_range(0, 3) == 0) begin
        bus.hold = 1'b1;
        holds++;
      end else begin
        bus.hold = 1'b0;
        holds = 0;
        c++;
      end
      @(negedge clk);
    end
    checkOutput($sformatf("%s_idle", tag), 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int l, d, f;
    tests    = 0;
    failures = 0;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.let_num    = '0;
    bus.dig_num    = '0;
    bus.first_char = '0;
    bus.hold       = 1'b0;

    vecs[0] = mkVec(4, 4, 0, "abcd0123/");
    vecs[1] = mkVec(3, 12, 24, "yza012345678901/");
    vecs[2] = mkVec(0, 0, 0, "/");
    vecs[3] = mkVec(0, 2, 0, "01/");
    vecs[4] = mkVec(1, 1, 30, "a0/");
    vecs[5] = mkVec(15, 0, 20, "uvwxyzabcdefghi/");
    vecs[6] = mkVec(2, 3, 25, "za012/");

    repeat (3) @(negedge clk);
    checkOutput("reset_state", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // Table-driven known streams
    for (int v = 0; v < 7; v++) begin
      expq.delete();
      for (int i = 0; i < vecs[v].len; i++)
        expq.push_back(vecs[v].exp_str[8*(vecs[v].len-1-i) +: 8]);
      applyStimulus(vecs[v].let_n, vecs[v].dig_n, vecs[v].first, 1'b0, $sformatf("vec%0d", v));
    end

    // Hold while 'b' is shown, with a stray start during the stream
    doStart(2, 1, 0);
    checkOutput("hold_a", 8'h61, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("hold_b0", 8'h62, 1'b1, 1'b1, 1'b0);
    bus.hold = 1'b1;
    @(negedge clk);
    checkOutput("hold_b1", 8'h62, 1'b1, 1'b1, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    checkOutput("hold_b2", 8'h62, 1'b1, 1'b1, 1'b0);
    bus.start = 1'b0;
    @(negedge clk);
    checkOutput("hold_b3", 8'h62, 1'b1, 1'b1, 1'b0);
    bus.hold = 1'b0;
    @(negedge clk);
    checkOutput("hold_0", 8'h30, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("hold_sep", 8'h2F, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("hold_idle0", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("hold_idle1", 8'h00, 1'b0, 1'b0, 1'b0);

    // Hold on the separator keeps done asserted
    doStart(0, 0, 0);
    bus.hold = 1'b1;
    checkOutput("sephold0", 8'h2F, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("sephold1", 8'h2F, 1'b1, 1'b1, 1'b1);
    bus.hold = 1'b0;
    @(negedge clk);
    checkOutput("sephold_idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // Reset on 'c' aborts the stream; a fresh start then runs completely
    doStart(5, 0, 0);
    checkOutput("rst_a", 8'h61, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("rst_b", 8'h62, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("rst_c", 8'h63, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_abort", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rst_quiet%0d", k), 8'h00, 1'b0, 1'b0, 1'b0);
    end
    buildExpected(5, 2, 0);
    applyStimulus(5, 2, 0, 1'b0, "rst_fresh");

    // start held high: back-to-back "a0/" with one idle cycle between
    bus.let_num    = 4'd1;
    bus.dig_num    = 4'd1;
    bus.first_char = 5'd30;
    bus.start      = 1'b1;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      checkOutput($sformatf("b2b%0d_a", r), 8'h61, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("b2b%0d_0", r), 8'h30, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("b2b%0d_sep", r), 8'h2F, 1'b1, 1'b1, 1'b1);
      if (r == 1) bus.start = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("b2b%0d_idle", r), 8'h00, 1'b0, 1'b0, 1'b0);
    end

    // hold in IDLE does not block a start
    bus.hold = 1'b1;
    doStart(1, 0, 3);
    bus.hold = 1'b0;
    checkOutput("idlehold_d", 8'h64, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("idlehold_sep", 8'h2F, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("idlehold_idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // Randomized streams with random hold against the reference model
    for (int n = 0; n < 25; n++) begin
      l = $urandom_range(0, 15);
      d = $urandom_range(0, 15);
      f = $urandom_range(0, 31);
      buildExpected(l, d, f);
      applyStimulus(l, d, f, 1'b1, $sformatf("rand%0d_l%0d_d%0d_f%0d", n, l, d, f));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
